// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and buffer control bundle.
package fetch_ctrl_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE    = 2'd0,
    FETCH_ST_REQ     = 2'd1,
    FETCH_ST_HOLD    = 2'd2,
    FETCH_ST_DISCARD = 2'd3
  } fetch_st_e;

  typedef struct packed {
    logic flush;    // drop both entries
    logic load;     // memory data into the output slot
    logic skid;     // memory data into the skid entry
    logic pop;      // skid entry into the output slot
    logic consume;  // output slot taken by ID with nothing replacing it
  } buf_ctrl_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer: output slot seen by ID plus one skid entry
// that catches a memory return arriving while ID is stalled.
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = INSTR_WIDTH,
  parameter int DATA_W = INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  buf_ctrl_t         i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid,
  output logic              o_full
);

  logic [DATA_W-1:0] r_out_data, r_skid_data;
  logic [ADDR_W-1:0] r_out_pc, r_skid_pc;
  logic              r_out_valid, r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_pc     <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
    end else if (i_ctrl.flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (i_ctrl.pop) begin
        r_out_data   <= r_skid_data;
        r_out_pc     <= r_skid_pc;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (i_ctrl.load) begin
        r_out_data  <= i_data;
        r_out_pc    <= i_pc;
        r_out_valid <= 1'b1;
      end else if (i_ctrl.consume) begin
        r_out_valid <= 1'b0;
      end
      if (i_ctrl.skid) begin
        r_skid_data  <= i_data;
        r_skid_pc    <= i_pc;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign o_data  = r_out_data;
  assign o_pc    = r_out_pc;
  assign o_valid = r_out_valid;
  assign o_full  = r_skid_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one memory request per PC, PC frozen while memory or ID
// stalls, wrong-path returns dropped after a flush.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = INSTR_WIDTH,
  parameter int DATA_W = INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] W_IF_PC,
  input  logic              W_ID_stall,
  input  logic              W_flush,
  output logic              W_pc_stall,
  output logic              W_imem_req,
  output logic [ADDR_W-1:0] W_imem_addr,
  input  logic              W_imem_ack,
  input  logic [DATA_W-1:0] W_imem_rdata,
  output logic [DATA_W-1:0] W_instr,
  output logic [ADDR_W-1:0] W_instr_pc,
  output logic              W_instr_valid
);

  fetch_st_e         r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              w_load_addr;
  logic              w_buf_full;
  logic              w_consume;
  buf_ctrl_t         w_ctrl;

  assign w_consume = W_instr_valid && !W_ID_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_ST_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_addr) r_addr <= W_IF_PC;
    end
  end

  // Address load and PC release are the same event, so PC and request never diverge.
  always_comb begin
    w_state_next = r_state;
    w_load_addr  = 1'b0;
    w_ctrl       = '0;
    case (r_state)
      FETCH_ST_IDLE: begin
        w_ctrl.flush = W_flush;
        w_load_addr  = 1'b1;
        w_state_next = FETCH_ST_REQ;
      end
      FETCH_ST_REQ: begin
        if (W_flush) begin
          w_ctrl.flush = 1'b1;
          w_load_addr  = 1'b1;
          // An outstanding request cannot be withdrawn; wait out its ack.
          w_state_next = W_imem_ack ? FETCH_ST_REQ : FETCH_ST_DISCARD;
        end else if (W_imem_ack) begin
          if (!W_instr_valid || !W_ID_stall) begin
            w_ctrl.load = 1'b1;
            w_load_addr = 1'b1;
          end else begin
            w_ctrl.skid  = 1'b1;
            w_state_next = FETCH_ST_HOLD;
          end
        end else begin
          w_ctrl.consume = w_consume;
        end
      end
      FETCH_ST_HOLD: begin
        if (W_flush) begin
          w_ctrl.flush = 1'b1;
          w_load_addr  = 1'b1;
          w_state_next = FETCH_ST_REQ;
        end else if (!W_ID_stall) begin
          w_ctrl.pop     = w_buf_full;
          w_ctrl.consume = !w_buf_full;
          w_load_addr    = 1'b1;
          w_state_next   = FETCH_ST_REQ;
        end
      end
      FETCH_ST_DISCARD: begin
        if (W_flush) begin
          w_ctrl.flush = 1'b1;
          w_load_addr  = 1'b1;
        end else if (W_imem_ack) begin
          w_state_next = FETCH_ST_REQ;
        end
      end
      default: w_state_next = FETCH_ST_IDLE;
    endcase
  end

  always_comb begin
    W_imem_req = (r_state == FETCH_ST_REQ) || (r_state == FETCH_ST_DISCARD);
    W_pc_stall = rst || !w_load_addr;
  end

  assign W_imem_addr = r_addr;

  fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_ctrl (w_ctrl),
    .i_data (W_imem_rdata),
    .i_pc   (r_addr),
    .o_data (W_instr),
    .o_pc   (W_instr_pc),
    .o_valid(W_instr_valid),
    .o_full (w_buf_full)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: IF PC model, variable-latency memory model,
// per-cycle vector tables and an in-order delivery scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] W_IF_PC;
  logic        W_ID_stall;
  logic        W_flush;
  logic        W_pc_stall;
  logic        W_imem_req;
  logic [31:0] W_imem_addr;
  logic        W_imem_ack;
  logic [31:0] W_imem_rdata;
  logic [31:0] W_instr;
  logic [31:0] W_instr_pc;
  logic        W_instr_valid;

  logic        id_stall  = 1'b0;
  logic        flush     = 1'b0;
  logic [31:0] flush_tgt = 32'h0;
  logic [31:0] base      = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] exp_next  = 32'h0;
  int          lat       = 0;
  int          mem_cnt;
  int          n_pass    = 0;
  int          n_total   = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic        eps;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .W_IF_PC      (W_IF_PC),
    .W_ID_stall   (W_ID_stall),
    .W_flush      (W_flush),
    .W_pc_stall   (W_pc_stall),
    .W_imem_req   (W_imem_req),
    .W_imem_addr  (W_imem_addr),
    .W_imem_ack   (W_imem_ack),
    .W_imem_rdata (W_imem_rdata),
    .W_instr      (W_instr),
    .W_instr_pc   (W_instr_pc),
    .W_instr_valid(W_instr_valid)
  );

  // IF stage: PC advances by 4 whenever enabled; a flush presents the redirect target.
  assign W_ID_stall = id_stall;
  assign W_flush    = flush;
  assign W_IF_PC    = flush ? flush_tgt : if_pc;
  always @(posedge clk) begin
    if (rst) if_pc <= base;
    else if (!W_pc_stall) if_pc <= W_IF_PC + 32'd4;
  end

  // Memory: ack after 'lat' wait cycles (0 = same cycle), data = ~address.
  assign W_imem_ack   = W_imem_req && (mem_cnt == lat);
  assign W_imem_rdata = ~W_imem_addr;
  always @(posedge clk) begin
    if (rst || !W_imem_req || W_imem_ack) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic sb();
    if (flush) begin
      exp_next = flush_tgt;
    end else if (W_instr_valid && !id_stall) begin
      $display("deliver pc=%h instr=%h", W_instr_pc, W_instr);
      chk("deliver_pc", W_instr_pc, exp_next);
      chk("deliver_data", W_instr, ~exp_next);
      exp_next += 32'd4;
    end
  endtask

  task automatic tick();
    sb();
    @(negedge clk);
  endtask

  task automatic add(input logic s, input logic f, input logic [31:0] t, input logic ev,
                     input logic [31:0] epc, input logic eps, input logic ereq,
                     input logic [31:0] eaddr);
    vec_t v;
    v.stall = s; v.flush = f; v.tgt = t; v.ev = ev;
    v.epc = epc; v.eps = eps; v.ereq = ereq; v.eaddr = eaddr;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input logic [31:0] b, input int l);
    rst = 1'b1; id_stall = 1'b0; flush = 1'b0; base = b; lat = l;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.valid", {31'b0, W_instr_valid}, 32'd0);
    chk("rst.instr", W_instr, 32'd0);
    chk("rst.instr_pc", W_instr_pc, 32'd0);
    chk("rst.addr", W_imem_addr, 32'd0);
    chk("rst.req", {31'b0, W_imem_req}, 32'd0);
    chk("rst.pc_stall", {31'b0, W_pc_stall}, 32'd1);
    exp_next = b;
    rst = 1'b0;
    #1;
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      id_stall = tbl[i].stall; flush = tbl[i].flush; flush_tgt = tbl[i].tgt;
      #1;
      $display("%s[%0d] stall=%b flush=%b valid=%b pc=%h pc_stall=%b req=%b addr=%h",
               nm, i, id_stall, flush, W_instr_valid, W_instr_pc, W_pc_stall,
               W_imem_req, W_imem_addr);
      chk($sformatf("%s[%0d].valid", nm, i), {31'b0, W_instr_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("%s[%0d].instr_pc", nm, i), W_instr_pc, tbl[i].epc);
        chk($sformatf("%s[%0d].instr", nm, i), W_instr, ~tbl[i].epc);
      end
      chk($sformatf("%s[%0d].pc_stall", nm, i), {31'b0, W_pc_stall}, {31'b0, tbl[i].eps});
      chk($sformatf("%s[%0d].req", nm, i), {31'b0, W_imem_req}, {31'b0, tbl[i].ereq});
      chk($sformatf("%s[%0d].addr", nm, i), W_imem_addr, tbl[i].eaddr);
      tick();
    end
    flush = 1'b0; id_stall = 1'b0;
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait memory, 5-cycle ID stall into HOLD, then flush coincident with ack.
    do_reset(32'h0, 0);
    add(0, 0, 0,        0, 0,        0, 0, 32'h0);
    add(0, 0, 0,        0, 0,        0, 1, 32'h0);
    add(0, 0, 0,        1, 32'h0,    0, 1, 32'h4);
    add(1, 0, 0,        1, 32'h4,    1, 1, 32'h8);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 1, 32'h4, 1, 0, 32'h8);
    add(0, 0, 0,        1, 32'h4,    0, 0, 32'h8);
    add(0, 0, 0,        1, 32'h8,    0, 1, 32'hC);
    add(0, 1, 32'h100,  1, 32'hC,    0, 1, 32'h10);
    add(0, 0, 0,        0, 0,        0, 1, 32'h100);
    add(0, 0, 0,        1, 32'h100,  0, 1, 32'h104);
    run_tbl("idstall");

    // 2-cycle memory, flush while a request is outstanding.
    do_reset(32'h0, 2);
    add(0, 0, 0,        0, 0,        0, 0, 32'h0);
    add(0, 0, 0,        0, 0,        1, 1, 32'h0);
    add(0, 0, 0,        0, 0,        1, 1, 32'h0);
    add(0, 0, 0,        0, 0,        0, 1, 32'h0);
    add(1, 0, 0,        1, 32'h0,    1, 1, 32'h4);
    add(1, 1, 32'h100,  1, 32'h0,    0, 1, 32'h4);
    add(0, 0, 0,        0, 0,        1, 1, 32'h100);
    add(0, 0, 0,        0, 0,        1, 1, 32'h100);
    add(0, 0, 0,        0, 0,        1, 1, 32'h100);
    add(0, 0, 0,        0, 0,        0, 1, 32'h100);
    add(0, 0, 0,        1, 32'h100,  1, 1, 32'h104);
    run_tbl("flush_out");

    // 1-cycle memory, flush on the same cycle as an ack with the output slot full.
    do_reset(32'h0, 1);
    add(0, 0, 0,        0, 0,        0, 0, 32'h0);
    add(0, 0, 0,        0, 0,        1, 1, 32'h0);
    add(0, 0, 0,        0, 0,        0, 1, 32'h0);
    add(1, 0, 0,        1, 32'h0,    1, 1, 32'h4);
    add(1, 1, 32'h200,  1, 32'h0,    0, 1, 32'h4);
    add(1, 0, 0,        0, 0,        1, 1, 32'h200);
    add(1, 0, 0,        0, 0,        0, 1, 32'h200);
    add(0, 0, 0,        1, 32'h200,  1, 1, 32'h204);
    run_tbl("flush_ack");

    // Zero-wait memory, flush in HOLD with both entries occupied.
    do_reset(32'h0, 0);
    add(0, 0, 0,        0, 0,        0, 0, 32'h0);
    add(0, 0, 0,        0, 0,        0, 1, 32'h0);
    add(1, 0, 0,        1, 32'h0,    1, 1, 32'h4);
    add(1, 1, 32'h200,  1, 32'h0,    0, 0, 32'h4);
    add(1, 0, 0,        0, 0,        0, 1, 32'h200);
    add(0, 0, 0,        1, 32'h200,  0, 1, 32'h204);
    add(0, 0, 0,        1, 32'h204,  0, 1, 32'h208);
    run_tbl("flush_hold");

    // 3-cycle memory: PC frozen 3 cycles per fetch, address stable, 1 instr / 4 cycles.
    do_reset(32'h1000, 3);
    chk("lat3[0].pc_stall", {31'b0, W_pc_stall}, 32'd0);
    tick();
    for (int c = 1; c <= 16; c++) begin
      #1;
      $display("lat3[%0d] valid=%b pc_stall=%b req=%b addr=%h", c, W_instr_valid,
               W_pc_stall, W_imem_req, W_imem_addr);
      chk($sformatf("lat3[%0d].pc_stall", c), {31'b0, W_pc_stall},
          (((c - 1) % 4) != 3) ? 32'd1 : 32'd0);
      chk($sformatf("lat3[%0d].req", c), {31'b0, W_imem_req}, 32'd1);
      chk($sformatf("lat3[%0d].addr", c), W_imem_addr, 32'h1000 + 32'(4 * ((c - 1) / 4)));
      chk($sformatf("lat3[%0d].valid", c), {31'b0, W_instr_valid},
          ((c >= 5) && (((c - 1) % 4) == 0)) ? 32'd1 : 32'd0);
      tick();
    end

    // Reset asserted while a flushed request is being discarded.
    do_reset(32'h2000, 3);
    tick();
    tick();
    flush = 1'b1; flush_tgt = 32'h300;
    #1;
    tick();
    flush = 1'b0;
    #1;
    $display("discard req=%b addr=%h pc_stall=%b", W_imem_req, W_imem_addr, W_pc_stall);
    chk("discard.req", {31'b0, W_imem_req}, 32'd1);
    chk("discard.addr", W_imem_addr, 32'h300);
    chk("discard.pc_stall", {31'b0, W_pc_stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    $display("mid_rst valid=%b req=%b addr=%h pc_stall=%b", W_instr_valid, W_imem_req,
             W_imem_addr, W_pc_stall);
    chk("mid_rst.valid", {31'b0, W_instr_valid}, 32'd0);
    chk("mid_rst.req", {31'b0, W_imem_req}, 32'd0);
    chk("mid_rst.addr", W_imem_addr, 32'd0);
    chk("mid_rst.pc_stall", {31'b0, W_pc_stall}, 32'd1);

    // Restart with zero-wait memory from the boot vector.
    do_reset(32'hBFC00000, 0);
    add(0, 0, 0,        0, 0,            0, 0, 32'h0);
    add(0, 0, 0,        0, 0,            0, 1, 32'hBFC00000);
    add(0, 0, 0,        1, 32'hBFC00000, 0, 1, 32'hBFC00004);
    add(0, 0, 0,        1, 32'hBFC00004, 0, 1, 32'hBFC00008);
    add(0, 0, 0,        1, 32'hBFC00008, 0, 1, 32'hBFC0000C);
    run_tbl("boot");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
